// File: rtl/uart_rd_pkg.sv
// Shared types and constants for the toggle-handshake status-register read sequencer.
package uart_rd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ      = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_SETTLE   = 3'd3,
        ST_SEND     = 3'd4,
        ST_NEXT     = 3'd5
    } state_t;

    localparam logic [7:0]  ADDR_MIN_DEF   = 8'h80;
    localparam logic [7:0]  ADDR_MAX_DEF   = 8'he4;
    localparam logic [31:0] OOR_WORD       = 32'h0;
    localparam int unsigned BYTES_PER_WORD = 4;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] cnt;
    } rd_cmd_t;

    // Byte lane for serialisation position idx, honouring the byte order.
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx,
                                             input logic msb_first);
        logic [1:0] lane;
        lane = msb_first ? 2'(2'd3 - idx) : idx;
        case (lane)
            2'd0:    return word[7:0];
            2'd1:    return word[15:8];
            2'd2:    return word[23:16];
            default: return word[31:24];
        endcase
    endfunction

endpackage

// File: rtl/uart_rd_ack_sync.sv
// Two-flop level synchroniser for the asynchronous ack toggle.
module uart_rd_ack_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic ack_async,
    output logic ack_s1,
    output logic ack_s
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_s1 <= 1'b0;
            ack_s  <= 1'b0;
        end else begin
            ack_s1 <= ack_async;
            ack_s  <= ack_s1;
        end
    end

endmodule

// File: rtl/uart_rd_ctrl.sv
// Requester-side read sequencer: issues toggle-handshake reads for a burst of
// status registers and streams each 32-bit word as 4 bytes to the UART TX.
module uart_rd_ctrl
    import uart_rd_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 1023,
    parameter int unsigned SETTLE_CYC  = 2,
    parameter logic [7:0]  ADDR_MIN    = ADDR_MIN_DEF,
    parameter logic [7:0]  ADDR_MAX    = ADDR_MAX_DEF,
    parameter bit          MSB_FIRST   = 1'b1
) (
    input  logic        core_clk,
    input  logic        core_rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_addr,
    input  logic [7:0]  cmd_cnt,
    output logic        uart_read_req,
    output logic [7:0]  uart_read_addr,
    input  logic        uart_read_ack,
    input  logic [31:0] status_bus_lock,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        timeout_err
);

    localparam int unsigned TIMER_W  = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int unsigned SETTLE_W = 4;

    state_t               state_q, state_n;
    rd_cmd_t              cmd_q, cmd_n;
    logic [31:0]          word_q, word_n;
    logic [1:0]           byte_idx_q, byte_idx_n;
    logic [TIMER_W-1:0]   timer_q, timer_n;
    logic [SETTLE_W-1:0]  settle_q, settle_n;
    logic                 req_q, req_n;
    logic [7:0]           raddr_q, raddr_n;
    logic [7:0]           tx_data_q, tx_data_n;
    logic                 tx_valid_q, tx_valid_n;
    logic                 busy_q, busy_n;
    logic                 timeout_q, timeout_n;
    logic                 ready_q, ready_n;
    logic                 ack_s1, ack_s;
    logic                 addr_ok;

    uart_rd_ack_sync u_ack_sync (
        .clk       (core_clk),
        .rst_n     (core_rst_n),
        .ack_async (uart_read_ack),
        .ack_s1    (ack_s1),
        .ack_s     (ack_s)
    );

    assign addr_ok = (cmd_q.addr >= ADDR_MIN) && (cmd_q.addr <= ADDR_MAX);

    // State register and all registered outputs.
    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            state_q    <= ST_IDLE;
            cmd_q      <= '0;
            word_q     <= '0;
            byte_idx_q <= '0;
            timer_q    <= '0;
            settle_q   <= '0;
            req_q      <= 1'b0;
            raddr_q    <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_n;
            cmd_q      <= cmd_n;
            word_q     <= word_n;
            byte_idx_q <= byte_idx_n;
            timer_q    <= timer_n;
            settle_q   <= settle_n;
            req_q      <= req_n;
            raddr_q    <= raddr_n;
            tx_data_q  <= tx_data_n;
            tx_valid_q <= tx_valid_n;
            busy_q     <= busy_n;
            timeout_q  <= timeout_n;
            ready_q    <= ready_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n    = state_q;
        cmd_n      = cmd_q;
        word_n     = word_q;
        byte_idx_n = byte_idx_q;
        timer_n    = timer_q;
        settle_n   = settle_q;
        req_n      = req_q;
        raddr_n    = raddr_q;
        tx_data_n  = tx_data_q;
        tx_valid_n = tx_valid_q;
        timeout_n  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && ready_q) begin
                    cmd_n.addr = cmd_addr;
                    cmd_n.cnt  = (cmd_cnt == 8'd0) ? 8'd1 : cmd_cnt;
                    state_n    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (!addr_ok) begin
                    word_n     = OOR_WORD;
                    tx_data_n  = word_byte(OOR_WORD, 2'd0, MSB_FIRST);
                    tx_valid_n = 1'b1;
                    byte_idx_n = 2'd0;
                    state_n    = ST_SEND;
                end else if (ack_s == req_q) begin
                    raddr_n = cmd_q.addr;
                    req_n   = ~req_q;
                    timer_n = '0;
                    state_n = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                // Timer holds elapsed cycles minus one; the abort lands on the
                // edge ACK_TIMEOUT cycles after the req toggle.
                if (ack_s == req_q) begin
                    settle_n = '0;
                    state_n  = ST_SETTLE;
                end else if (timer_q == TIMER_W'(ACK_TIMEOUT - 1)) begin
                    timeout_n = 1'b1;
                    state_n   = ST_IDLE;
                end else begin
                    timer_n = timer_q + TIMER_W'(1);
                end
            end
            ST_SETTLE: begin
                if (settle_q == SETTLE_W'(SETTLE_CYC)) begin
                    word_n     = status_bus_lock;
                    tx_data_n  = word_byte(status_bus_lock, 2'd0, MSB_FIRST);
                    tx_valid_n = 1'b1;
                    byte_idx_n = 2'd0;
                    state_n    = ST_SEND;
                end else begin
                    settle_n = settle_q + SETTLE_W'(1);
                end
            end
            ST_SEND: begin
                if (tx_valid_q && tx_ready) begin
                    if (byte_idx_q == 2'(BYTES_PER_WORD - 1)) begin
                        tx_valid_n = 1'b0;
                        state_n    = ST_NEXT;
                    end else begin
                        byte_idx_n = byte_idx_q + 2'd1;
                        tx_data_n  = word_byte(word_q, byte_idx_q + 2'd1, MSB_FIRST);
                    end
                end
            end
            ST_NEXT: begin
                cmd_n.cnt = cmd_q.cnt - 8'd1;
                if (cmd_q.cnt == 8'd1) begin
                    state_n = ST_IDLE;
                end else begin
                    cmd_n.addr = cmd_q.addr + 8'd1;
                    state_n    = ST_REQ;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        busy_n  = (state_n != ST_IDLE);
        // ack_s1 is next cycle's ack_s, so the registered ready tracks the level match exactly.
        ready_n = (state_n == ST_IDLE) && (ack_s1 == req_n);
    end

    assign cmd_ready      = ready_q;
    assign uart_read_req  = req_q;
    assign uart_read_addr = raddr_q;
    assign tx_data        = tx_data_q;
    assign tx_valid       = tx_valid_q;
    assign busy           = busy_q;
    assign timeout_err    = timeout_q;

endmodule

// File: tb/tb_uart_rd_ctrl.sv
// Scoreboard bench for uart_rd_ctrl with a loopback toggle-handshake responder.
module tb_uart_rd_ctrl;

    localparam int unsigned TO       = 1023;
    localparam int unsigned SETTLE   = 2;
    localparam int          RESP_LAT = 3;

    logic        core_clk;
    logic        core_rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_addr;
    logic [7:0]  cmd_cnt;
    logic        uart_read_req;
    logic [7:0]  uart_read_addr;
    logic        resp_ack;
    logic [31:0] status_bus_lock;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        timeout_err;

    uart_rd_ctrl #(
        .ACK_TIMEOUT (TO),
        .SETTLE_CYC  (SETTLE),
        .ADDR_MIN    (8'h80),
        .ADDR_MAX    (8'he4),
        .MSB_FIRST   (1'b1)
    ) dut (
        .core_clk        (core_clk),
        .core_rst_n      (core_rst_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_addr        (cmd_addr),
        .cmd_cnt         (cmd_cnt),
        .uart_read_req   (uart_read_req),
        .uart_read_addr  (uart_read_addr),
        .uart_read_ack   (resp_ack),
        .status_bus_lock (status_bus_lock),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .busy            (busy),
        .timeout_err     (timeout_err)
    );

    initial begin
        core_clk = 1'b0;
        forever #5 core_clk = ~core_clk;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic in_rng(input logic [7:0] a);
        return (a >= 8'h80) && (a <= 8'he4);
    endfunction

    function automatic logic [31:0] word_of(input logic [7:0] a);
        return (a == 8'h80) ? 32'h12345678 : {a, ~a, a ^ 8'h5a, 8'hc3};
    endfunction

    logic [7:0] exp_q[$];
    int exp_tog = 0;
    int toggles = 0, hs_cnt = 0, cyc = 0, t_toggle = 0, t_to = 0, to_cycles = 0, stall_cyc = 0;
    int resp_mode = 0;
    int stall_hs = -1;
    logic hold_ready = 1'b0;

    // Responder: mode 0 answers after RESP_LAT cycles, 1 stays silent, 2 answers at once.
    initial begin
        int lat;
        resp_ack = 1'b0;
        status_bus_lock = 32'h0;
        lat = 0;
        forever begin
            @(negedge core_clk);
            if (!core_rst_n) begin
                resp_ack = 1'b0;
                lat = 0;
            end else if (uart_read_req != resp_ack && resp_mode != 1) begin
                if (resp_mode == 2 || lat == RESP_LAT) begin
                    status_bus_lock = word_of(uart_read_addr);
                    resp_ack = uart_read_req;
                    lat = 0;
                end else begin
                    lat++;
                end
            end
        end
    end

    // TX ready driver with a one-shot 7-cycle stall on a chosen byte.
    initial begin
        int last_stalled;
        int stall_left;
        last_stalled = -1;
        stall_left = 0;
        tx_ready = 1'b1;
        forever begin
            @(posedge core_clk);
            #1;
            if (stall_hs >= 0 && hs_cnt == stall_hs && last_stalled != stall_hs) begin
                last_stalled = stall_hs;
                stall_left = 7;
            end else if (stall_left > 0) begin
                stall_left--;
            end
            tx_ready = !(hold_ready || stall_left > 0);
        end
    end

    // Output monitor: scoreboard pop on each TX handshake, hold checks under back-pressure.
    initial begin
        logic req_prev;
        logic held;
        logic [7:0] held_data;
        req_prev = 1'b0;
        held = 1'b0;
        held_data = 8'h0;
        forever begin
            @(negedge core_clk);
            cyc++;
            if (!core_rst_n) begin
                req_prev = 1'b0;
                held = 1'b0;
            end else begin
                if (uart_read_req !== req_prev) begin
                    toggles++;
                    t_toggle = cyc;
                    req_prev = uart_read_req;
                end
                if (timeout_err) begin
                    to_cycles++;
                    t_to = cyc;
                end
                if (held)
                    check_eq("bp_hold", 32'({tx_valid, tx_data}), 32'({1'b1, held_data}));
                if (tx_valid && !tx_ready) begin
                    stall_cyc++;
                    if (!held) begin
                        held = 1'b1;
                        held_data = tx_data;
                    end
                end else begin
                    held = 1'b0;
                end
                if (tx_valid && tx_ready) begin
                    hs_cnt++;
                    if (exp_q.size() == 0)
                        check_eq("byte_expected", 32'(exp_q.size()), 32'd1);
                    else
                        check_eq("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic push_exp(input logic [7:0] a0, input logic [7:0] c0);
        logic [7:0] a;
        logic [31:0] w;
        int n;
        n = (c0 == 8'd0) ? 1 : int'(c0);
        a = a0;
        for (int i = 0; i < n; i++) begin
            w = in_rng(a) ? word_of(a) : 32'h0;
            for (int b = 3; b >= 0; b--) exp_q.push_back(w[b*8 +: 8]);
            if (in_rng(a)) exp_tog++;
            a = a + 8'd1;
        end
    endtask

    task automatic launch(input logic [7:0] a, input logic [7:0] c);
        int n;
        n = 0;
        do begin
            @(negedge core_clk);
            n++;
        end while (!cmd_ready && n < 50);
        check_eq("cmd_ready_seen", 32'(cmd_ready), 32'd1);
        cmd_addr = a;
        cmd_cnt = c;
        cmd_valid = 1'b1;
        @(posedge core_clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge core_clk);
            n++;
        end while ((busy || exp_q.size() != 0) && n < budget);
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic reset_pulse(input string tag);
        @(posedge core_clk);
        #2;
        core_rst_n = 1'b0;
        #1;
        check_eq(tag, 32'({cmd_ready, uart_read_req, uart_read_addr, tx_valid, tx_data, busy, timeout_err}), 32'd0);
        repeat (3) @(negedge core_clk);
        exp_q.delete();
        resp_mode = 0;
        hold_ready = 1'b0;
        core_rst_n = 1'b1;
        @(posedge core_clk);
        #1;
    endtask

    initial begin
        int n;
        int base;
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        core_rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr = 8'h0;
        cmd_cnt = 8'h0;
        repeat (3) @(negedge core_clk);
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check_eq("rst_req", 32'(uart_read_req), 32'd0);
        check_eq("rst_addr", 32'(uart_read_addr), 32'd0);
        check_eq("rst_tx_valid", 32'(tx_valid), 32'd0);
        check_eq("rst_tx_data", 32'(tx_data), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_timeout", 32'(timeout_err), 32'd0);
        core_rst_n = 1'b1;
        @(posedge core_clk);
        #1;
        check_eq("ready_after_reset", 32'(cmd_ready), 32'd1);

        // Single read of 0x80: bytes 12 34 56 78, one toggle.
        push_exp(8'h80, 8'd1);
        launch(8'h80, 8'd1);
        wait_idle(200);
        check_eq("single_toggles", 32'(toggles), 32'(exp_tog));

        // Burst e3..e5 with e5 out of range; commands offered while busy are ignored.
        push_exp(8'he3, 8'd3);
        launch(8'he3, 8'd3);
        cmd_addr = 8'h90;
        cmd_cnt = 8'd1;
        cmd_valid = 1'b1;
        repeat (5) begin
            @(negedge core_clk);
            check_eq("ready_while_busy", 32'(cmd_ready), 32'd0);
        end
        cmd_valid = 1'b0;
        wait_idle(400);
        check_eq("burst_toggles", 32'(toggles), 32'(exp_tog));

        // Back-pressure of 7 cycles on the second byte.
        base = stall_cyc;
        stall_hs = hs_cnt + 1;
        push_exp(8'h81, 8'd1);
        launch(8'h81, 8'd1);
        wait_idle(200);
        stall_hs = -1;
        check_eq("stall_cycles", 32'(stall_cyc - base), 32'd7);
        check_eq("bp_toggles", 32'(toggles), 32'(exp_tog));

        // Silent responder: timeout after exactly TO cycles, then a late ack.
        resp_mode = 1;
        base = to_cycles;
        launch(8'h81, 8'd1);
        exp_tog++;
        wait_idle(TO + 100);
        check_eq("timeout_delay", 32'(t_to - t_toggle), 32'(TO));
        check_eq("timeout_pulse_width", 32'(to_cycles - base), 32'd1);
        repeat (10) @(negedge core_clk);
        check_eq("ready_blocked", 32'(cmd_ready), 32'd0);
        @(posedge core_clk);
        #1;
        resp_mode = 2;
        n = 0;
        do begin
            @(negedge core_clk);
            n++;
        end while (!cmd_ready && n < 6);
        check_eq("late_ack_ready", 32'(cmd_ready), 32'd1);
        check_eq("late_ack_within3", 32'(n <= 3), 32'd1);
        resp_mode = 0;
        check_eq("timeout_toggles", 32'(toggles), 32'(exp_tog));

        // Count 0 is a single register.
        push_exp(8'h84, 8'd0);
        launch(8'h84, 8'd0);
        wait_idle(200);

        // Address wrap ff -> 00: two zero words, no handshakes.
        push_exp(8'hff, 8'd2);
        launch(8'hff, 8'd2);
        wait_idle(200);
        check_eq("wrap_toggles", 32'(toggles), 32'(exp_tog));

        // Reset while waiting for ack, then a normal read.
        resp_mode = 1;
        base = toggles;
        launch(8'h80, 8'd1);
        exp_tog++;
        n = 0;
        do begin
            @(negedge core_clk);
            n++;
        end while (toggles == base && n < 20);
        repeat (5) @(negedge core_clk);
        reset_pulse("rst_in_wait_ack");
        push_exp(8'h80, 8'd1);
        launch(8'h80, 8'd1);
        wait_idle(200);

        // Reset while a byte is stalled in SEND, then a normal read.
        hold_ready = 1'b1;
        launch(8'h82, 8'd1);
        exp_tog++;
        n = 0;
        do begin
            @(negedge core_clk);
            n++;
        end while (!tx_valid && n < 50);
        check_eq("send_reached", 32'(tx_valid), 32'd1);
        reset_pulse("rst_in_send");
        push_exp(8'h82, 8'd1);
        launch(8'h82, 8'd1);
        wait_idle(200);
        check_eq("final_toggles", 32'(toggles), 32'(exp_tog));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rd_ctrl.md
Name: uart_rd_ctrl

Overview:
- Requester-side sequencer for the toggle-handshake status-register read path.
- Accepts a read command (start address and count) from the UART command parser and drives the req/addr toggle handshake once per register.
- Synchronises the returning ack and samples the locked 32-bit status word.
- Serialises each word as 4 bytes to the UART transmitter. Supports burst reads of consecutive addresses, an ack timeout and abort.

Parameters:
- ACK_TIMEOUT, 1023: cycles to wait for the ack level to match req before aborting.
- SETTLE_CYC, 2: extra cycles after ack match before sampling status_bus_lock (range 0..15).
- ADDR_MIN, 8'h80: lowest implemented status address.
- ADDR_MAX, 8'he4: highest implemented status address.
- MSB_FIRST, 1: 1 sends byte[31:24] first; 0 sends byte[7:0] first.

Ports:
- core_clk  in  1  block clock.
- core_rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_addr  in  8  first register address.
- cmd_cnt  in  8  number of registers; 0 is treated as 1.
- uart_read_req  out  1  toggle request to the responder.
- uart_read_addr  out  8  read address; held stable from req toggle until ack match.
- uart_read_ack  in  1  toggle ack from the responder, asynchronous.
- status_bus_lock  in  32  locked word from the responder, quasi-static.
- tx_data  out  8  byte to the UART TX.
- tx_valid  out  1  byte valid.
- tx_ready  in  1  TX accepts the byte when tx_valid & tx_ready.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  one-cycle pulse on abort.

Behaviour:
- Reset values:
  - uart_read_req=0, uart_read_addr=0, tx_valid=0, tx_data=0, busy=0, timeout_err=0.
  - cmd_ready=0 during reset; cmd_ready=1 in the first cycle after reset.
  - ack synchroniser flops=0.
- Ack synchroniser: 2 flops, ack_s = sync stage 2. Completion condition is level match ack_s == uart_read_req; edges are never counted.
- States: IDLE, REQ, WAIT_ACK, SETTLE, SEND, NEXT.
- IDLE:
  - cmd_ready = (ack_s == uart_read_req).
  - On accept: latch addr and cnt (cnt 0 becomes 1), then go to REQ.
- REQ:
  - If addr is in ADDR_MIN..ADDR_MAX: drive uart_read_addr=addr, toggle uart_read_req, clear the timer, go to WAIT_ACK.
  - Otherwise: load word=32'h0, no handshake, go to SEND.
- WAIT_ACK:
  - Timer increments each cycle.
  - If ack_s == uart_read_req: go to SETTLE.
  - Else if timer == ACK_TIMEOUT: pulse timeout_err, drop the remaining burst, go to IDLE.
  - cmd_ready stays 0 until a late ack restores the level match. No spurious byte is sent.
- SETTLE: wait SETTLE_CYC cycles, then word <= status_bus_lock and go to SEND.
- SEND:
  - Present 4 bytes in the MSB_FIRST order.
  - tx_data and tx_valid are registered and held until tx_ready; a byte advances only on the handshake.
  - Back-pressure of any length is legal.
  - After the 4th handshake go to NEXT.
- NEXT:
  - cnt -= 1. If cnt == 0 go to IDLE; else addr += 1 and go to REQ.
  - addr wraps 8'hff to 8'h00 (modulo 8 bits); wrapped addresses fall under the out-of-range rule.
- Timing:
  - Minimum from req toggle to sample: 2 sync cycles plus responder latency plus SETTLE_CYC.
  - From sample, tx_valid rises on the next cycle.
- Interlocks:
  - cmd_valid while busy is ignored; cmd_ready=0.
  - A new request is never issued while ack_s != uart_read_req.
- Reset mid-operation: all state returns to reset values; uart_read_req returns to 0. The responder must be reset in the same reset domain.

Decomposition:
- Shared package uart_rd_pkg:
  - state encoding constants.
  - ADDR_MIN and ADDR_MAX defaults.
  - OOR_WORD = 32'h0.
  - byte-count constant 4.
- One natural sub-module: uart_rd_ack_sync (2-flop level synchroniser). The FSM, timer and serialiser stay inline.

Test Plan:
- Single read, loopback responder returning 32'h12345678 for 8'h80, tx_ready=1 -> bytes 12,34,56,78; uart_read_req toggles once; busy falls after the 4th byte.
- Burst cmd_addr=8'he3, cmd_cnt=3 -> e3 word, e4 word, then 8'he5 out of range gives 00,00,00,00 with no req toggle for e5; 12 bytes total.
- tx_ready low for 7 cycles on the 2nd byte -> tx_data and tx_valid held stable; no byte lost or duplicated.
- Responder silent -> timeout_err pulses exactly ACK_TIMEOUT cycles after the toggle; no tx_valid; cmd_ready stays 0 until a late ack is injected, then rises within 3 cycles.
- Wrap case: cmd_addr=8'hff, cmd_cnt=2 -> two out-of-range zero words (ff, 00) and no handshakes.
- core_rst_n asserted in WAIT_ACK and in SEND -> all outputs at reset values immediately; a new command after release completes normally.
